// File: rtl/uart_cmd_rx_if.sv
// Serial-in / command-out bundle between the host UART line and the commutation block.
// The receiver uses the slave view; whoever drives the line and consumes the command uses master.
interface uart_cmd_rx_if;
  logic       rx;
  logic [7:0] cmd_byte;
  logic       byte_valid;
  logic       frame_err;
  logic       timeout;
  logic       busy;

  modport slave (
    input  rx,
    output cmd_byte, byte_valid, frame_err, timeout, busy
  );

  modport master (
    output rx,
    input  cmd_byte, byte_valid, frame_err, timeout, busy
  );
endinterface

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver holding the last good byte as the motor command.
// Framing errors leave the command alone; a traffic timeout forces it to 0.
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 50000000
) (
  input logic         clk,
  input logic         rst,
  uart_cmd_rx_if.slave cmd_if
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          rx_meta_q, rx_s_q;
  logic [2:0]    state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    cmd_q;
  logic          byte_valid_q, frame_err_q, timeout_q;
  logic          deliver, ferr, tmo_fire;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    deliver   = 1'b0;
    ferr      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d   = S_START;
          bit_cnt_d = '0;
        end
      end
      S_START: begin
        // Mid-start-bit recheck rejects short glitches without flagging anything.
        if (bit_cnt_q == HALF_LAST) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (rx_s_q) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr    = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        // Wait out a held-low line so a break yields only one frame error.
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  generate
    if (TIMEOUT_CLKS > 0) begin : g_tmo
      localparam int TW = $clog2(TIMEOUT_CLKS + 1);
      localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
      localparam logic [TW-1:0] TMO_SAT  = TW'(TIMEOUT_CLKS);
      logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

      // Parking at TMO_SAT after firing keeps the pulse one-shot until the next good byte.
      always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (deliver)                     tmo_cnt_d = '0;
        else if (tmo_cnt_q == TMO_LAST)  tmo_cnt_d = TMO_SAT;
        else if (tmo_cnt_q != TMO_SAT)   tmo_cnt_d = tmo_cnt_q + 1'b1;
      end

      assign tmo_fire = (tmo_cnt_q == TMO_LAST) && !deliver;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_cnt_q <= '0;
        else     tmo_cnt_q <= tmo_cnt_d;
      end
    end else begin : g_no_tmo
      assign tmo_fire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      cmd_q        <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      rx_meta_q    <= cmd_if.rx;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= deliver;
      frame_err_q  <= ferr;
      timeout_q    <= tmo_fire;
      if (deliver)       cmd_q <= shift_q;
      else if (tmo_fire) cmd_q <= '0;
    end
  end

  assign cmd_if.cmd_byte   = cmd_q;
  assign cmd_if.byte_valid = byte_valid_q;
  assign cmd_if.frame_err  = frame_err_q;
  assign cmd_if.timeout    = timeout_q;
  assign cmd_if.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: unit A has a 2000-cycle timeout, unit B has the timeout disabled.
module tb_uart_cmd_rx;
  localparam int C = 16;
  localparam int H = C / 2;
  localparam int T = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;

  always #5 clk = ~clk;

  uart_cmd_rx_if bus_a ();
  uart_cmd_rx_if bus_b ();
  assign bus_a.rx = rx_a;
  assign bus_b.rx = rx_b;

  uart_cmd_rx #(.CLKS_PER_BIT(C), .TIMEOUT_CLKS(T)) dut_a (.clk(clk), .rst(rst), .cmd_if(bus_a.slave));
  uart_cmd_rx #(.CLKS_PER_BIT(C), .TIMEOUT_CLKS(0)) dut_b (.clk(clk), .rst(rst), .cmd_if(bus_b.slave));

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts events and remembers when they happened.
  int bv_a = 0, fe_a = 0, to_a = 0, busy_a = 0, bv_b = 0, to_b = 0;
  int bv_cyc_a = 0, to_cyc_a = 0;
  logic [7:0] got_a[$];
  always @(negedge clk) begin
    if (bus_a.byte_valid) begin
      bv_a     <= bv_a + 1;
      bv_cyc_a <= cyc;
      got_a.push_back(bus_a.cmd_byte);
    end
    if (bus_a.frame_err) fe_a <= fe_a + 1;
    if (bus_a.timeout) begin
      to_a     <= to_a + 1;
      to_cyc_a <= cyc;
    end
    if (bus_a.busy)       busy_a <= busy_a + 1;
    if (bus_b.byte_valid) bv_b <= bv_b + 1;
    if (bus_b.timeout)    to_b <= to_b + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drive_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input logic stop, output int t0);
    $display("tx unit %0d byte %h stop %b at cycle %0d", sel, d, stop, cyc);
    t0 = cyc;
    drive_rx(sel, 1'b0);
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive_rx(sel, d[i]);
      repeat (C) @(negedge clk);
    end
    drive_rx(sel, stop);
    repeat (C) @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    vectors++; if (bus_a.cmd_byte !== 8'h00) begin miscompares++; $display("FAIL reset_cmd: got %h expected 00", bus_a.cmd_byte); end
    vectors++; if ({bus_a.busy, bus_a.byte_valid, bus_a.frame_err, bus_a.timeout} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 0000", {bus_a.busy, bus_a.byte_valid, bus_a.frame_err, bus_a.timeout}); end
    @(negedge clk);
    rst = 1'b0;
    idle(50);
    vectors++; if (bus_a.cmd_byte !== 8'h00 || bus_a.busy !== 1'b0) begin
      miscompares++; $display("FAIL idle_state: got cmd %h busy %b expected 00 0", bus_a.cmd_byte, bus_a.busy); end
    vectors++; if (bv_a + fe_a + to_a !== 0) begin
      miscompares++; $display("FAIL idle_pulses: got %0d pulses expected 0", bv_a + fe_a + to_a); end
  endtask

  task automatic test_single;
    int b0, t0, lat;
    b0 = bv_a;
    send_frame(1'b0, 8'h01, 1'b1, t0);
    idle(20);
    lat = bv_cyc_a - t0;
    vectors++; if (bv_a - b0 !== 1) begin miscompares++; $display("FAIL single_count: got %0d expected 1", bv_a - b0); end
    vectors++; if (bus_a.cmd_byte !== 8'h01) begin miscompares++; $display("FAIL single_cmd: got %h expected 01", bus_a.cmd_byte); end
    vectors++; if (lat < H + 9 * C + 3 || lat > H + 9 * C + 5) begin
      miscompares++; $display("FAIL single_latency: got %0d expected %0d +/-1", lat, H + 9 * C + 4); end
    idle(40);
    vectors++; if (bus_a.cmd_byte !== 8'h01 || bv_a - b0 !== 1) begin
      miscompares++; $display("FAIL single_hold: got cmd %h count %0d expected 01 1", bus_a.cmd_byte, bv_a - b0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b [4];
    int b0, f0, n0, t0;
    exp_b[0] = 8'h80; exp_b[1] = 8'hC0; exp_b[2] = 8'hA0; exp_b[3] = 8'h70;
    b0 = bv_a; f0 = fe_a; n0 = got_a.size();
    for (int i = 0; i < 4; i++) send_frame(1'b0, exp_b[i], 1'b1, t0);
    idle(20);
    vectors++; if (bv_a - b0 !== 4) begin miscompares++; $display("FAIL b2b_count: got %0d expected 4", bv_a - b0); end
    vectors++; if (fe_a - f0 !== 0) begin miscompares++; $display("FAIL b2b_frame_err: got %0d expected 0", fe_a - f0); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got_a.size() <= n0 + i) begin
        miscompares++; $display("FAIL b2b_byte%0d: got none expected %h", i, exp_b[i]);
      end else if (got_a[n0 + i] !== exp_b[i]) begin
        miscompares++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got_a[n0 + i], exp_b[i]);
      end
    end
    vectors++; if (bus_a.cmd_byte !== 8'h70) begin miscompares++; $display("FAIL b2b_cmd: got %h expected 70", bus_a.cmd_byte); end
  endtask

  task automatic test_glitch;
    int b0, f0, u0;
    b0 = bv_a; f0 = fe_a; u0 = busy_a;
    $display("tx unit 0 glitch 4 cycles at cycle %0d", cyc);
    rx_a = 1'b0;
    repeat (4) @(negedge clk);
    rx_a = 1'b1;
    idle(30);
    vectors++; if (busy_a - u0 < 1 || busy_a - u0 > 12) begin
      miscompares++; $display("FAIL glitch_busy: got %0d cycles expected 1..12", busy_a - u0); end
    vectors++; if (bv_a - b0 !== 0 || fe_a - f0 !== 0) begin
      miscompares++; $display("FAIL glitch_pulses: got bv %0d fe %0d expected 0 0", bv_a - b0, fe_a - f0); end
    vectors++; if (bus_a.cmd_byte !== 8'h70 || bus_a.busy !== 1'b0) begin
      miscompares++; $display("FAIL glitch_state: got cmd %h busy %b expected 70 0", bus_a.cmd_byte, bus_a.busy); end
  endtask

  task automatic test_frame_err;
    int b0, f0, t0;
    b0 = bv_a; f0 = fe_a;
    send_frame(1'b0, 8'h55, 1'b0, t0);
    repeat (100) @(negedge clk);
    rx_a = 1'b1;
    idle(10);
    vectors++; if (fe_a - f0 !== 1) begin miscompares++; $display("FAIL ferr_count: got %0d expected 1", fe_a - f0); end
    vectors++; if (bv_a - b0 !== 0 || bus_a.cmd_byte !== 8'h70) begin
      miscompares++; $display("FAIL ferr_cmd: got cmd %h bv %0d expected 70 0", bus_a.cmd_byte, bv_a - b0); end
    send_frame(1'b0, 8'h02, 1'b1, t0);
    idle(20);
    vectors++; if (bv_a - b0 !== 1 || bus_a.cmd_byte !== 8'h02) begin
      miscompares++; $display("FAIL ferr_recover: got cmd %h bv %0d expected 02 1", bus_a.cmd_byte, bv_a - b0); end
    vectors++; if (fe_a - f0 !== 1) begin miscompares++; $display("FAIL ferr_after: got %0d expected 1", fe_a - f0); end
  endtask

  task automatic test_timeout;
    int t_base, t0, n, lat;
    t_base = to_a;
    send_frame(1'b0, 8'h03, 1'b1, t0);
    idle(4);
    vectors++; if (bus_a.cmd_byte !== 8'h03) begin miscompares++; $display("FAIL tmo_pre_cmd: got %h expected 03", bus_a.cmd_byte); end
    n = 0;
    while (to_a == t_base && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    lat = to_cyc_a - bv_cyc_a;
    vectors++; if (to_a - t_base !== 1) begin miscompares++; $display("FAIL tmo_fire: got %0d pulses expected 1", to_a - t_base); end
    vectors++; if (lat < T - 1 || lat > T + 1) begin miscompares++; $display("FAIL tmo_latency: got %0d expected %0d +/-1", lat, T); end
    vectors++; if (bus_a.cmd_byte !== 8'h00) begin miscompares++; $display("FAIL tmo_cmd: got %h expected 00", bus_a.cmd_byte); end
    idle(4000);
    vectors++; if (to_a - t_base !== 1) begin miscompares++; $display("FAIL tmo_repeat: got %0d pulses expected 1", to_a - t_base); end
    send_frame(1'b0, 8'h04, 1'b1, t0);
    idle(20);
    vectors++; if (bus_a.cmd_byte !== 8'h04) begin miscompares++; $display("FAIL tmo_recover: got %h expected 04", bus_a.cmd_byte); end
  endtask

  task automatic test_reset_mid;
    int b0;
    b0 = bv_a;
    $display("tx unit 0 byte ff aborted by reset at cycle %0d", cyc);
    rx_a = 1'b0;
    repeat (C) @(negedge clk);
    rx_a = 1'b1;
    repeat (4 * C + H) @(negedge clk);
    #1;
    vectors++; if (bus_a.busy !== 1'b1) begin miscompares++; $display("FAIL rmid_busy: got %b expected 1", bus_a.busy); end
    rst = 1'b1;
    #1;
    vectors++; if (bus_a.cmd_byte !== 8'h00) begin miscompares++; $display("FAIL rmid_cmd: got %h expected 00", bus_a.cmd_byte); end
    vectors++; if ({bus_a.busy, bus_a.byte_valid, bus_a.frame_err, bus_a.timeout} !== 4'b0000) begin
      miscompares++; $display("FAIL rmid_flags: got %b expected 0000", {bus_a.busy, bus_a.byte_valid, bus_a.frame_err, bus_a.timeout}); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(6 * C);
    vectors++; if (bv_a - b0 !== 0 || bus_a.cmd_byte !== 8'h00) begin
      miscompares++; $display("FAIL rmid_discard: got cmd %h bv %0d expected 00 0", bus_a.cmd_byte, bv_a - b0); end
  endtask

  task automatic test_no_timeout;
    int b0, tb0, ta0, t0;
    b0 = bv_b; ta0 = to_a;
    send_frame(1'b1, 8'h5A, 1'b1, t0);
    idle(20);
    vectors++; if (bv_b - b0 !== 1 || bus_b.cmd_byte !== 8'h5A) begin
      miscompares++; $display("FAIL notmo_rx: got cmd %h bv %0d expected 5a 1", bus_b.cmd_byte, bv_b - b0); end
    tb0 = to_b;
    idle(10000);
    vectors++; if (to_b - tb0 !== 0 || bus_b.timeout !== 1'b0) begin
      miscompares++; $display("FAIL notmo_pulse: got %0d pulses expected 0", to_b - tb0); end
    vectors++; if (bus_b.cmd_byte !== 8'h5A) begin miscompares++; $display("FAIL notmo_cmd: got %h expected 5a", bus_b.cmd_byte); end
    vectors++; if (to_a - ta0 < 1) begin miscompares++; $display("FAIL tmo_unit_a: got %0d pulses expected >=1", to_a - ta0); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_timeout;
    test_reset_mid;
    test_no_timeout;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- 8N1 UART receiver directly upstream of the 8-bit-to-sensored-BLDC commutation block.
- Deserialises the host serial line into a held 8-bit command byte that drives the commutation block's 8-bit `In` input.
- Safety behaviour: a framing error never changes the command; loss of traffic forces the command to 0 (all motors off) after a timeout.

Parameters:
- CLKS_PER_BIT, 434: clk cycles per UART bit (50 MHz / 115200). Must be >= 8.
- TIMEOUT_CLKS, 50000000: clk cycles with no valid byte before cmd_byte is forced to 0. A value of 0 disables the timeout.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- rx  input  1  asynchronous serial line, idle high
- cmd_byte  output  8  last valid received byte, held; drives commutation `In`
- byte_valid  output  1  one-cycle pulse when cmd_byte is updated
- frame_err  output  1  one-cycle pulse on a bad stop bit
- timeout  output  1  one-cycle pulse when cmd_byte is forced to 0 by the timeout
- busy  output  1  high while the FSM is not in IDLE

Behaviour:
- Reset (async, rst=1):
  - cmd_byte=0; byte_valid, frame_err, timeout, busy = 0.
  - FSM = IDLE; all counters = 0.
  - Synchroniser flops = 1.
  - Asserting rst mid-frame aborts the frame; the partial byte is discarded.
- Synchroniser: rx passes through 2 flops (rx_s). All decisions use rx_s; 2-cycle input latency.
- Bit counter: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
- FSM states:
  - IDLE: rx_s=0 -> START, bit counter cleared.
  - START: wait CLKS_PER_BIT/2 (integer division) cycles, then resample rx_s. If 0 -> DATA, counters cleared. If 1 -> IDLE (glitch/false start; no flags).
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register, LSB first. After bit 7 -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - If 1: next cycle cmd_byte <= shifted byte, byte_valid=1 for exactly 1 cycle, FSM -> IDLE.
    - If 0: frame_err=1 for 1 cycle, cmd_byte unchanged, FSM -> BREAK.
  - BREAK: stay until rx_s=1, then -> IDLE. A held-low line (break) produces exactly one frame_err.
- busy = (state != IDLE).
- Re-receipt: a byte equal to the current cmd_byte still pulses byte_valid.
- Back-to-back frames: a start bit immediately following the stop-bit sample is accepted. There is no dead time beyond the return to IDLE.
- Timeout counter:
  - Width $clog2(TIMEOUT_CLKS+1).
  - Increments every cycle; cleared to 0 on the byte_valid cycle.
  - On reaching TIMEOUT_CLKS-1: cmd_byte <= 0, timeout pulses 1 cycle, counter saturates (no further pulses) until the next valid byte.
  - Framing errors do not clear the counter.
  - If a valid byte completes on the same cycle the timeout would fire, the valid byte wins: cmd_byte = new byte, timeout not asserted, counter cleared.
  - TIMEOUT_CLKS=0: counter and timeout logic are absent; timeout tied to 0.
- Latency: byte_valid asserts CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 4 cycles (±1) after the rx falling edge at the pin.

Test Plan (CLKS_PER_BIT=16, TIMEOUT_CLKS=2000 unless stated):
- Reset then idle line -> cmd_byte=0, busy=0, no pulses. Then send 0x01 -> one byte_valid pulse, cmd_byte=0x01, held afterwards; latency within ±1 of the formula above.
- Send 0x80, 0xC0, 0xA0, 0x70 back-to-back with no idle gap -> four byte_valid pulses; cmd_byte steps through each value; frame_err never set.
- Low glitch of 4 cycles on rx -> returns to IDLE, busy high for at most 12 cycles, no byte_valid or frame_err, cmd_byte unchanged.
- Send 0x55 with stop bit driven 0, then rx held low for 100 cycles -> exactly one frame_err pulse, cmd_byte keeps its previous value. After rx returns high, 0x02 is received normally.
- Send 0x03, then stay idle for 2000 cycles -> timeout pulses once, cmd_byte=0, no repeat pulse within a further 4000 cycles. Sending 0x04 -> cmd_byte=0x04.
- Assert rst during DATA bit 4 of 0xFF -> all outputs at reset values immediately; after release the 0xFF frame is not reported. With TIMEOUT_CLKS=0 and 10000 idle cycles, the timeout output never asserts.
